// File: rtl/unidade_controle.sv
// Multi-cycle control FSM sequencing fetch, pointer/operand reads, execute, store and I/O
// for the accumulator datapath; optional memory timeout drives a sticky error halt.
module unidade_controle #(
    parameter int TIMEOUT_MEM = 0,
    parameter int LARG_CONT   = 16
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [15:0]          operacao_i,
    input  logic [3:0]           modo_i,
    input  logic                 flag_n_i,
    input  logic                 flag_z_i,
    input  logic                 mem_pronta_i,
    input  logic                 ent_valida_i,
    input  logic                 sai_pronta_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [1:0]           sel_end_o,
    output logic                 carga_ri_o,
    output logic                 inc_pc_o,
    output logic                 carga_pc_o,
    output logic                 sel_pc_o,
    output logic                 carga_rdm_o,
    output logic                 carga_ac_o,
    output logic [2:0]           sel_ula_o,
    output logic [1:0]           sel_b_o,
    output logic                 ent_pronta_o,
    output logic                 sai_valida_o,
    output logic                 parado_o,
    output logic                 erro_mem_o,
    output logic [LARG_CONT-1:0] n_instr_o,
    output logic [3:0]           estado_o
);

    // state    | meaning
    // BUSCA    | instruction fetch       DECOD    | decoder settles on new RI
    // PONTEIRO | indirect pointer read   OPERANDO | operand read
    // EXEC     | ALU load / jump         ESCRITA  | store AC to memory
    // ENTRADA  | wait input word         SAIDA    | wait output accept
    // PARADO   | halted until reset
    localparam logic [3:0] BUSCA    = 4'd0;
    localparam logic [3:0] DECOD    = 4'd1;
    localparam logic [3:0] PONTEIRO = 4'd2;
    localparam logic [3:0] OPERANDO = 4'd3;
    localparam logic [3:0] EXEC     = 4'd4;
    localparam logic [3:0] ESCRITA  = 4'd5;
    localparam logic [3:0] ENTRADA  = 4'd6;
    localparam logic [3:0] SAIDA    = 4'd7;
    localparam logic [3:0] PARADO   = 4'd8;

    localparam int TW = (TIMEOUT_MEM > 1) ? $clog2(TIMEOUT_MEM) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_MEM > 0) ? TIMEOUT_MEM - 1 : 0);

    logic [3:0]           state_q, state_d;
    logic                 erro_q, erro_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [LARG_CONT-1:0] cnt_q, cnt_d;

    logic       mem_req_c, mem_we_c, carga_ri_c, inc_pc_c, carga_pc_c, sel_pc_c;
    logic       carga_rdm_c, carga_ac_c, ent_pronta_c, sai_valida_c, parado_c;
    logic [1:0] sel_end_c, sel_b_c;
    logic [2:0] sel_ula_c, ula_op;

    logic op_nop, op_sta, op_lda, op_add, op_sub, op_and, op_or, op_not;
    logic op_j, op_jn, op_jz, op_in, op_out, op_shr, op_shl, op_hlt;
    logic op_alu, op_jmp, op_un, m_dir, m_ind, m_im, m_sop;

    assign {op_nop, op_sta, op_lda, op_add, op_sub, op_and, op_or, op_not,
            op_j, op_jn, op_jz, op_in, op_out, op_shr, op_shl, op_hlt} = operacao_i;
    assign {m_dir, m_ind, m_im, m_sop} = modo_i;
    assign op_alu = op_add | op_sub | op_and | op_or;
    assign op_jmp = op_j | op_jn | op_jz;
    assign op_un  = op_not | op_shr | op_shl;

    always_comb begin
        ula_op = 3'd0;
        if (op_add)      ula_op = 3'd1;
        else if (op_sub) ula_op = 3'd2;
        else if (op_and) ula_op = 3'd3;
        else if (op_or)  ula_op = 3'd4;
        else if (op_not) ula_op = 3'd5;
        else if (op_shr) ula_op = 3'd6;
        else if (op_shl) ula_op = 3'd7;
    end

    always_comb begin
        state_d      = state_q;
        erro_d       = erro_q;
        tmr_d        = '0;
        cnt_d        = cnt_q;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        sel_end_c    = 2'd0;
        carga_ri_c   = 1'b0;
        inc_pc_c     = 1'b0;
        carga_pc_c   = 1'b0;
        sel_pc_c     = 1'b0;
        carga_rdm_c  = 1'b0;
        carga_ac_c   = 1'b0;
        sel_ula_c    = 3'd0;
        sel_b_c      = 2'd0;
        ent_pronta_c = 1'b0;
        sai_valida_c = 1'b0;
        parado_c     = 1'b0;
        case (state_q)
            BUSCA: begin
                mem_req_c = 1'b1;
                if (mem_pronta_i) begin
                    carga_ri_c = 1'b1;
                    inc_pc_c   = 1'b1;
                    state_d    = DECOD;
                end
            end
            DECOD: begin
                if (op_hlt)                           state_d = PARADO;
                else if (op_nop || operacao_i == '0)  state_d = BUSCA;
                else if (op_un)                       state_d = EXEC;
                else if (op_in)                       state_d = ENTRADA;
                else if (op_out)                      state_d = SAIDA;
                else if (m_ind)                       state_d = PONTEIRO;
                else if (m_im)                        state_d = (op_lda | op_alu | op_jmp) ? EXEC : BUSCA;
                else if (m_dir || m_sop)              state_d = (op_lda | op_alu) ? OPERANDO :
                                                                op_sta ? ESCRITA : EXEC;
                else                                  state_d = BUSCA;
            end
            PONTEIRO: begin
                mem_req_c = 1'b1;
                sel_end_c = 2'd1;
                if (mem_pronta_i) begin
                    carga_rdm_c = 1'b1;
                    state_d     = op_jmp ? EXEC : op_sta ? ESCRITA : OPERANDO;
                end
            end
            OPERANDO: begin
                mem_req_c = 1'b1;
                sel_end_c = m_ind ? 2'd2 : 2'd1;
                if (mem_pronta_i) begin
                    carga_rdm_c = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                carga_ac_c = op_lda | op_alu | op_un;
                sel_ula_c  = ula_op;
                sel_b_c    = m_im ? 2'd1 : 2'd0;
                carga_pc_c = op_j | (op_jn & flag_n_i) | (op_jz & flag_z_i);
                sel_pc_c   = m_ind;
                state_d    = BUSCA;
            end
            ESCRITA: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                sel_end_c = m_ind ? 2'd2 : 2'd1;
                if (mem_pronta_i) state_d = BUSCA;
            end
            ENTRADA: begin
                ent_pronta_c = 1'b1;
                if (ent_valida_i) begin
                    carga_ac_c = 1'b1;
                    sel_b_c    = 2'd2;
                    state_d    = BUSCA;
                end
            end
            SAIDA: begin
                sai_valida_c = 1'b1;
                if (sai_pronta_i) state_d = BUSCA;
            end
            PARADO:  parado_c = 1'b1;
            default: state_d = BUSCA;
        endcase

        // Counter runs only while a request is outstanding; the halt lands the cycle after the last wait.
        if (TIMEOUT_MEM > 0 && mem_req_c && !mem_pronta_i) begin
            if (tmr_q == TMO_LAST) begin
                state_d = PARADO;
                erro_d  = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end

        if (state_d == BUSCA && state_q != BUSCA) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= BUSCA;
            erro_q  <= 1'b0;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            erro_q  <= erro_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req_o    = mem_req_c & ~reset_i;
    assign mem_we_o     = mem_we_c & ~reset_i;
    assign sel_end_o    = reset_i ? 2'd0 : sel_end_c;
    assign carga_ri_o   = carga_ri_c & ~reset_i;
    assign inc_pc_o     = inc_pc_c & ~reset_i;
    assign carga_pc_o   = carga_pc_c & ~reset_i;
    assign sel_pc_o     = sel_pc_c & ~reset_i;
    assign carga_rdm_o  = carga_rdm_c & ~reset_i;
    assign carga_ac_o   = carga_ac_c & ~reset_i;
    assign sel_ula_o    = reset_i ? 3'd0 : sel_ula_c;
    assign sel_b_o      = reset_i ? 2'd0 : sel_b_c;
    assign ent_pronta_o = ent_pronta_c & ~reset_i;
    assign sai_valida_o = sai_valida_c & ~reset_i;
    assign parado_o     = parado_c & ~reset_i;
    assign erro_mem_o   = erro_q & ~reset_i;
    assign n_instr_o    = reset_i ? '0 : cnt_q;
    assign estado_o     = reset_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: plays memory, I/O devices and decoder, and predicts each
// cycle's strobes from an instruction-level description of the control sequence.
module tb_unidade_controle;
    localparam int TMO = 4;
    localparam int LC  = 4;

    localparam int I_NOP = 15, I_STA = 14, I_LDA = 13, I_ADD = 12, I_SUB = 11, I_AND = 10;
    localparam int I_OR = 9, I_NOT = 8, I_J = 7, I_JN = 6, I_JZ = 5, I_IN = 4, I_OUT = 3;
    localparam int I_SHR = 2, I_SHL = 1, I_HLT = 0, I_INV = -1;
    localparam logic [3:0] M_DIR = 4'b1000, M_IND = 4'b0100, M_IM = 4'b0010, M_SOP = 4'b0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [15:0] operacao = '0;
    logic [3:0]  modo = '0;
    logic        flag_n = 0, flag_z = 0, mem_pronta = 0, ent_valida = 0, sai_pronta = 0;
    logic        mem_req, mem_we, carga_ri, inc_pc, carga_pc, sel_pc, carga_rdm, carga_ac;
    logic        ent_pronta, sai_valida, parado, erro_mem;
    logic [1:0]  sel_end, sel_b;
    logic [2:0]  sel_ula;
    logic [LC-1:0] n_instr;
    logic [3:0]  estado;

    unidade_controle #(.TIMEOUT_MEM(TMO), .LARG_CONT(LC)) dut (
        .clock_i(clk), .reset_i(rst), .operacao_i(operacao), .modo_i(modo),
        .flag_n_i(flag_n), .flag_z_i(flag_z), .mem_pronta_i(mem_pronta),
        .ent_valida_i(ent_valida), .sai_pronta_i(sai_pronta),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .sel_end_o(sel_end), .carga_ri_o(carga_ri),
        .inc_pc_o(inc_pc), .carga_pc_o(carga_pc), .sel_pc_o(sel_pc), .carga_rdm_o(carga_rdm),
        .carga_ac_o(carga_ac), .sel_ula_o(sel_ula), .sel_b_o(sel_b), .ent_pronta_o(ent_pronta),
        .sai_valida_o(sai_valida), .parado_o(parado), .erro_mem_o(erro_mem),
        .n_instr_o(n_instr), .estado_o(estado)
    );

    typedef struct packed {
        logic       mem_req, mem_we;
        logic [1:0] sel_end;
        logic       carga_ri, inc_pc, carga_pc, sel_pc, carga_rdm, carga_ac;
        logic [2:0] sel_ula;
        logic [1:0] sel_b;
        logic       ent_pronta, sai_valida, parado, erro_mem;
    } outs_t;

    outs_t obs;
    assign obs = {mem_req, mem_we, sel_end, carga_ri, inc_pc, carga_pc, sel_pc, carga_rdm,
                  carga_ac, sel_ula, sel_b, ent_pronta, sai_valida, parado, erro_mem};

    int n_chk = 0, n_pass = 0, n_fail = 0;
    logic [LC-1:0] exp_n = '0;

    // Selects are compared only while the strobe they steer is expected active.
    task automatic chk_outs(input string tag, input outs_t e);
        outs_t o, x;
        o = obs;
        x = e;
        if (!x.mem_req)  begin o.sel_end = '0; x.sel_end = '0; end
        if (!x.carga_ac) begin o.sel_ula = '0; x.sel_ula = '0; o.sel_b = '0; x.sel_b = '0; end
        if (!x.carga_pc) begin o.sel_pc = 1'b0; x.sel_pc = 1'b0; end
        n_chk++;
        assert (o === x) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, o, x);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, o, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mem_pronta = 1'($urandom_range(0, 1));
        ent_valida = 1'($urandom_range(0, 1));
        sai_pronta = 1'($urandom_range(0, 1));
        flag_n     = 1'($urandom_range(0, 1));
        flag_z     = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [2:0] ula_code(input int op);
        case (op)
            I_ADD:   return 3'd1;
            I_SUB:   return 3'd2;
            I_AND:   return 3'd3;
            I_OR:    return 3'd4;
            I_NOT:   return 3'd5;
            I_SHR:   return 3'd6;
            I_SHL:   return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    task automatic fetch(input int lat, input string tag);
        outs_t e;
        for (int c = 0; c <= lat; c++) begin
            tick();
            rst        = 1'b0;
            operacao   = 16'($urandom);
            modo       = 4'($urandom);
            mem_pronta = (c == lat);
            #1;
            if (c == 0) chk_val({tag, "/n_instr"}, 32'(n_instr), 32'(exp_n));
            e = '0;
            e.mem_req  = 1'b1;
            e.carga_ri = (c == lat);
            e.inc_pc   = (c == lat);
            chk_outs({tag, "/fetch"}, e);
        end
    endtask

    task automatic mem_acc(input int lat, input logic [1:0] se, input logic wr, input string tag);
        outs_t e;
        for (int c = 0; c <= lat; c++) begin
            tick();
            mem_pronta = (c == lat);
            #1;
            e = '0;
            e.mem_req   = 1'b1;
            e.mem_we    = wr;
            e.sel_end   = se;
            e.carga_rdm = !wr && (c == lat);
            chk_outs(tag, e);
        end
    endtask

    task automatic exec(input int op, input logic [3:0] md, input int fn, input string tag);
        outs_t e;
        tick();
        if (fn >= 0) flag_n = fn[0];
        #1;
        e = '0;
        if (op == I_LDA || op == I_ADD || op == I_SUB || op == I_AND || op == I_OR ||
            op == I_NOT || op == I_SHR || op == I_SHL) begin
            e.carga_ac = 1'b1;
            e.sel_ula  = ula_code(op);
            e.sel_b    = md[1] ? 2'd1 : 2'd0;
        end
        e.carga_pc = (op == I_J) || (op == I_JN && flag_n) || (op == I_JZ && flag_z);
        e.sel_pc   = md[2];
        chk_outs({tag, "/exec"}, e);
    endtask

    task automatic io_wait(input logic is_in, input int w, input string tag);
        outs_t e;
        for (int c = 0; c <= w; c++) begin
            tick();
            if (is_in) ent_valida = (c == w);
            else       sai_pronta = (c == w);
            #1;
            e = '0;
            e.ent_pronta = is_in;
            e.sai_valida = !is_in;
            e.carga_ac   = is_in && (c == w);
            e.sel_b      = 2'd2;
            chk_outs({tag, is_in ? "/in" : "/out"}, e);
        end
    endtask

    // One non-halting instruction: fetch, decode, then the phases its opcode/mode call for.
    task automatic run_instr(input int op, input logic [3:0] md, input int la, input int lb,
                             input int lc, input int w, input int fn, input string tag);
        logic is_alu, is_jmp, is_un, ind, im;
        fetch(la, tag);
        tick();
        operacao = (op < 0) ? 16'h0 : (16'h1 << op);
        modo     = md;
        #1;
        chk_outs({tag, "/decod"}, '0);
        is_alu = (op == I_ADD || op == I_SUB || op == I_AND || op == I_OR);
        is_jmp = (op == I_J || op == I_JN || op == I_JZ);
        is_un  = (op == I_NOT || op == I_SHR || op == I_SHL);
        ind    = md[2];
        im     = md[1];
        if (op == I_INV || op == I_NOP) begin
        end else if (is_un) begin
            exec(op, md, fn, tag);
        end else if (op == I_IN) begin
            io_wait(1'b1, w, tag);
        end else if (op == I_OUT) begin
            io_wait(1'b0, w, tag);
        end else if (ind) begin
            mem_acc(lb, 2'd1, 1'b0, {tag, "/ptr"});
            if (is_jmp)            exec(op, md, fn, tag);
            else if (op == I_STA)  mem_acc(lc, 2'd2, 1'b1, {tag, "/wr"});
            else begin
                mem_acc(lc, 2'd2, 1'b0, {tag, "/opnd"});
                exec(op, md, fn, tag);
            end
        end else if (im) begin
            if (op != I_STA) exec(op, md, fn, tag);
        end else begin
            if (op == I_LDA || is_alu) begin
                mem_acc(lb, 2'd1, 1'b0, {tag, "/opnd"});
                exec(op, md, fn, tag);
            end else if (op == I_STA) begin
                mem_acc(lb, 2'd1, 1'b1, {tag, "/wr"});
            end else begin
                exec(op, md, fn, tag);
            end
        end
        exp_n = exp_n + 1'b1;
    endtask

    initial begin
        outs_t e;
        int op;

        for (int i = 0; i < 3; i++) begin
            tick();
            rst      = 1'b1;
            operacao = 16'($urandom);
            modo     = 4'($urandom);
            #1;
            chk_val("reset_all", {5'd0, obs, estado, n_instr}, 32'd0);
        end

        run_instr(I_LDA, M_DIR, 0, 0, 0, 0, -1, "lda_dir");
        run_instr(I_ADD, M_IND, 0, 3, 3, 0, -1, "add_ind");
        run_instr(I_JN, M_IM, 1, 0, 0, 0, 0, "jn_im_n0");
        run_instr(I_JN, M_IM, 0, 0, 0, 0, 1, "jn_im_n1");
        run_instr(I_STA, M_IM, 2, 0, 0, 0, -1, "sta_im");
        run_instr(I_OUT, M_SOP, 0, 0, 0, 5, -1, "out_wait5");
        run_instr(I_INV, M_DIR, 0, 0, 0, 0, -1, "invalid");
        run_instr(I_STA, M_IND, 1, 2, 3, 0, -1, "sta_ind");

        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(1, 16));
            if (op == 16) op = I_INV;
            run_instr(op, 4'b0001 << $urandom_range(0, 3), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), -1, "rand");
        end

        for (int c = 0; c < TMO; c++) begin
            tick();
            operacao   = 16'($urandom);
            mem_pronta = 1'b0;
            #1;
            e = '0;
            e.mem_req = 1'b1;
            chk_outs("tmo_wait", e);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            e = '0;
            e.parado   = 1'b1;
            e.erro_mem = 1'b1;
            chk_outs("tmo_halt", e);
            chk_val("tmo_n_instr", 32'(n_instr), 32'(exp_n));
        end

        for (int i = 0; i < 2; i++) begin
            tick();
            rst = 1'b1;
            #1;
            chk_val("reset_after_tmo", {5'd0, obs, estado, n_instr}, 32'd0);
        end
        exp_n = '0;
        run_instr(I_LDA, M_IM, 0, 0, 0, 0, -1, "lda_im_post");
        run_instr(I_IN, M_DIR, 3, 0, 0, 2, -1, "in_post");

        fetch(1, "hlt");
        tick();
        operacao = 16'h0001;
        modo     = M_DIR;
        #1;
        chk_outs("hlt/decod", '0);
        for (int c = 0; c < 6; c++) begin
            tick();
            mem_pronta = 1'b1;
            ent_valida = 1'b1;
            sai_pronta = 1'b1;
            operacao   = 16'($urandom);
            #1;
            e = '0;
            e.parado = 1'b1;
            chk_outs("hlt/parado", e);
            chk_val("hlt/n_instr", 32'(n_instr), 32'(exp_n));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
